// File: rtl/agc_timepulse_gen.sv
// agc_timepulse_gen: memory-cycle timepulse generator.
// Produces one-hot timepulses T, one-hot phases PHS and the RT/WT/CT strobes.
// Handles GOJAM restart sequencing, stopping at a cycle boundary and
// single-cycle stepping under monitor control (MSTP/MSTRT).
// Every output is decoded from registered state; no input reaches an output
// combinationally.
module agc_timepulse_gen #(
  parameter int N_TP         = 12,
  parameter int N_PHS        = 4,
  parameter int CLK_DIV      = 1,
  parameter int RT_PHS       = 0,
  parameter int WT_PHS       = 2,
  parameter int CT_PHS       = 3,
  parameter int GOJAM_CYCLES = 2,
  parameter int MCW          = 16
) (
  input  logic             CLOCK,
  input  logic             SIM_RST,
  input  logic             GOJAM_REQ,
  input  logic             STOP_REQ,
  input  logic             MSTP,
  input  logic             MSTRT,
  output logic [N_TP-1:0]  T,
  output logic [N_PHS-1:0] PHS,
  output logic             RT,
  output logic             WT,
  output logic             CT,
  output logic             GOJAM,
  output logic             CYC_END,
  output logic             STOPPED,
  output logic [MCW-1:0]   MCYC
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (N_PHS > 1) ? $clog2(N_PHS) : 1;
  localparam int TP_W  = (N_TP > 1) ? $clog2(N_TP) : 1;
  localparam int JC_W  = (GOJAM_CYCLES > 1) ? $clog2(GOJAM_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(N_PHS - 1);
  localparam logic [TP_W-1:0]  TP_MAX  = TP_W'(N_TP - 1);
  localparam logic [JC_W-1:0]  JC_MAX  = JC_W'(GOJAM_CYCLES - 1);
  localparam logic [PH_W-1:0]  RT_P    = PH_W'(RT_PHS);
  localparam logic [PH_W-1:0]  WT_P    = PH_W'(WT_PHS);
  localparam logic [PH_W-1:0]  CT_P    = PH_W'(CT_PHS);

  // A strobe phase that does not exist would silently never fire.
  if (RT_PHS >= N_PHS) begin : g_bad_rt
    $error("agc_timepulse_gen: RT_PHS must be less than N_PHS");
  end
  if (WT_PHS >= N_PHS) begin : g_bad_wt
    $error("agc_timepulse_gen: WT_PHS must be less than N_PHS");
  end
  if (CT_PHS >= N_PHS) begin : g_bad_ct
    $error("agc_timepulse_gen: CT_PHS must be less than N_PHS");
  end

  typedef enum logic [1:0] {
    MODE_JAM  = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STOP = 2'd2,
    MODE_STEP = 2'd3
  } mode_t;

  mode_t            mode;
  logic [DIV_W-1:0] div;
  logic [PH_W-1:0]  ph;
  logic [TP_W-1:0]  tp;
  logic [JC_W-1:0]  jcnt;
  logic             last_clk;

  assign last_clk = (div == DIV_MAX) && (ph == PH_MAX) && (tp == TP_MAX);

  // Mode sequencing and the div/ph/tp counter chain; restart beats stop/step, which beat counting.
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      mode <= MODE_JAM;
      div  <= '0;
      ph   <= '0;
      tp   <= '0;
      jcnt <= '0;
      MCYC <= '0;
    end else if (GOJAM_REQ) begin
      mode <= MODE_JAM;
      div  <= '0;
      ph   <= '0;
      tp   <= '0;
      jcnt <= '0;
    end else if (mode == MODE_STOP) begin
      div <= '0;
      ph  <= '0;
      tp  <= '0;
      if (MSTP && MSTRT) begin
        mode <= MODE_STEP;
      end else if (!MSTP && !STOP_REQ) begin
        mode <= MODE_RUN;
      end
    end else begin
      if (div == DIV_MAX) begin
        div <= '0;
        if (ph == PH_MAX) begin
          ph <= '0;
          if (tp == TP_MAX) begin
            tp <= '0;
          end else begin
            tp <= tp + 1'b1;
          end
        end else begin
          ph <= ph + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
      if (last_clk) begin
        MCYC <= MCYC + 1'b1;
        if (mode == MODE_JAM) begin
          if (jcnt == JC_MAX) begin
            jcnt <= '0;
            mode <= MODE_RUN;
          end else begin
            jcnt <= jcnt + 1'b1;
          end
        end else if (STOP_REQ || MSTP) begin
          mode <= MODE_STOP;
        end else begin
          mode <= MODE_RUN;
        end
      end
    end
  end

  // Output decode from the registered mode and counters; everything is dark while stopped.
  always_comb begin
    T       = '0;
    PHS     = '0;
    RT      = 1'b0;
    WT      = 1'b0;
    CT      = 1'b0;
    GOJAM   = (mode == MODE_JAM);
    STOPPED = (mode == MODE_STOP);
    CYC_END = 1'b0;
    if (mode != MODE_STOP) begin
      T[tp]   = 1'b1;
      PHS[ph] = 1'b1;
      RT      = (ph == RT_P);
      WT      = (ph == WT_P);
      CT      = (ph == CT_P);
      CYC_END = last_clk;
    end
  end

endmodule
